// File: rtl/demux_pkg.sv
// Shared types and defaults for the one-to-two demux buffer.
package demux_pkg;

  localparam int unsigned DEMUX_WIDTH_DEFAULT = 64;
  localparam int unsigned DEMUX_DEPTH_DEFAULT = 2;

  typedef logic [15:0] stall_cnt_t;

  typedef enum logic [1:0] {
    StEmpty,
    StPartial,
    StFull
  } fifo_state_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/one_to_two_demux_buffer_if.sv
// Upstream and dual downstream valid/ready bundle of the demux buffer.
interface one_to_two_demux_buffer_if #(
  parameter int unsigned WIDTH = demux_pkg::DEMUX_WIDTH_DEFAULT
);
  logic             in_valid;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data0, out_data1
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data0, out_data1
  );
endinterface

// File: rtl/demux_fifo.sv
// Small per-output FIFO; occupancy is tracked both as a count and as an EMPTY/PARTIAL/FULL state.
module demux_fifo
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH_DEFAULT,
  parameter int unsigned DEPTH = DEMUX_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [CntW-1:0] CntLastM1 = CntW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  fifo_state_e      state_q, state_d;
  logic             do_push, do_pop;

  // A full FIFO refuses pushes even when it pops in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StEmpty;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: begin
        if (do_push) state_d = StPartial;
      end
      StPartial: begin
        if (do_push && !do_pop && count_q == CntLastM1)  state_d = StFull;
        else if (do_pop && !do_push && count_q == CntOne) state_d = StEmpty;
      end
      StFull: begin
        if (do_pop) state_d = StPartial;
      end
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    full      = (state_q == StFull);
    empty     = (state_q == StEmpty);
    head_data = (state_q == StEmpty) ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/one_to_two_demux_buffer.sv
// Steers each upstream word into one of two output FIFOs and counts upstream stall cycles.
module one_to_two_demux_buffer
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH_DEFAULT,
  parameter int unsigned DEPTH = DEMUX_DEPTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset_n,
  one_to_two_demux_buffer_if.slave    bus,
  output stall_cnt_t                  overflow_cnt
);

  logic       full0, full1, empty0, empty1;
  logic       in_ready, push0, push1;
  stall_cnt_t ovf_q, ovf_d;

  // Only the selected side's fullness matters; out_ready never reaches in_ready.
  assign in_ready     = bus.in_sel ? !full1 : !full0;
  assign push0        = bus.in_valid && in_ready && !bus.in_sel;
  assign push1        = bus.in_valid && in_ready && bus.in_sel;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = {!empty1, !empty0};

  demux_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push0),
    .push_data(bus.in_data),
    .pop      (bus.out_ready[0]),
    .full     (full0),
    .empty    (empty0),
    .head_data(bus.out_data0)
  );

  demux_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push1),
    .push_data(bus.in_data),
    .pop      (bus.out_ready[1]),
    .full     (full1),
    .empty    (empty1),
    .head_data(bus.out_data1)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (bus.in_valid && !in_ready && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ovf_q <= '0;
    else          ovf_q <= ovf_d;
  end

  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_one_to_two_demux_buffer.sv
// Bench for one_to_two_demux_buffer: directed scenarios plus random traffic against a queue model.
module tb_one_to_two_demux_buffer;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] overflow_cnt;

  one_to_two_demux_buffer_if #(.WIDTH(WIDTH)) bus ();

  one_to_two_demux_buffer #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  int unsigned ovf_m = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive one cycle starting just after a falling edge, compare against the model, then advance.
  task automatic step(input logic v, input logic s, input logic [63:0] d, input logic [1:0] r,
                      output logic acc);
    logic exp_rdy;
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = r;
    #1;
    exp_rdy = s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    check("out_valid", 64'(bus.out_valid), {62'b0, q1.size() != 0, q0.size() != 0});
    check("out_data0", bus.out_data0, (q0.size() != 0) ? q0[0] : 64'h0);
    check("out_data1", bus.out_data1, (q1.size() != 0) ? q1[0] : 64'h0);
    check("overflow_cnt", 64'(overflow_cnt), 64'(ovf_m));
    acc = v && exp_rdy;
    if (r[0] && q0.size() != 0) void'(q0.pop_front());
    if (r[1] && q1.size() != 0) void'(q1.pop_front());
    if (acc) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
    if (v && !exp_rdy && ovf_m < 32'hFFFF) ovf_m++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic        acc;
    logic        pv, ps;
    logic [63:0] pd;
    int          tries;

    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 2'b00;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'h1);
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_out_data0", bus.out_data0, 64'h0);
    check("rst_overflow", 64'(overflow_cnt), 64'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Steering
    step(1'b1, 1'b0, 64'hA1, 2'b11, acc);
    step(1'b1, 1'b1, 64'hB2, 2'b11, acc);
    step(1'b0, 1'b0, 64'h0, 2'b11, acc);
    step(1'b0, 1'b0, 64'h0, 2'b11, acc);

    // Full backpressure on output 1, then independence of output 0
    step(1'b1, 1'b1, 64'h1, 2'b00, acc);
    step(1'b1, 1'b1, 64'h2, 2'b00, acc);
    repeat (3) step(1'b1, 1'b1, 64'h3, 2'b00, acc);
    step(1'b1, 1'b0, 64'h55, 2'b00, acc);
    step(1'b0, 1'b0, 64'h0, 2'b00, acc);
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 8) begin
      step(1'b1, 1'b1, 64'h3, 2'b10, acc);
      tries++;
    end
    check("retry_accepted", 64'(acc), 64'h1);
    repeat (4) step(1'b0, 1'b0, 64'h0, 2'b11, acc);

    // Pop on full: push refused that cycle, accepted the next
    step(1'b1, 1'b0, 64'hC1, 2'b00, acc);
    step(1'b1, 1'b0, 64'hC2, 2'b00, acc);
    step(1'b1, 1'b0, 64'h77, 2'b01, acc);
    check("popfull_refused", 64'(acc), 64'h0);
    step(1'b1, 1'b0, 64'h77, 2'b01, acc);
    check("popfull_accepted", 64'(acc), 64'h1);
    repeat (3) step(1'b0, 1'b0, 64'h0, 2'b01, acc);

    // Pointer wrap on output 0
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 64'h100 + 64'(i), 2'b00, acc);
      step(1'b0, 1'b0, 64'h0, 2'b01, acc);
    end

    // Random traffic, holding each word until it is accepted
    pv = 1'b0;
    ps = 1'b0;
    pd = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pv) begin
        pv = ($urandom_range(0, 3) != 0);
        ps = 1'($urandom_range(0, 1));
        pd = {$urandom, $urandom};
      end
      step(pv, ps, pd, 2'($urandom_range(0, 3)), acc);
      if (acc) pv = 1'b0;
    end
    repeat (3) step(1'b0, 1'b0, 64'h0, 2'b11, acc);

    // Reset mid-stream with two words held in output 0
    step(1'b1, 1'b1, 64'hF0, 2'b00, acc);
    step(1'b1, 1'b1, 64'hF1, 2'b00, acc);
    step(1'b1, 1'b1, 64'hF2, 2'b00, acc);
    step(1'b1, 1'b0, 64'hD1, 2'b00, acc);
    step(1'b1, 1'b0, 64'hD2, 2'b00, acc);
    bus.in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'h0);
    check("midrst_overflow", 64'(overflow_cnt), 64'h0);
    check("midrst_out_data0", bus.out_data0, 64'h0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'h1);
    q0.delete();
    q1.delete();
    ovf_m = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 64'h0, 2'b11, acc);

    // Stall counter saturation
    step(1'b1, 1'b1, 64'hE1, 2'b00, acc);
    step(1'b1, 1'b1, 64'hE2, 2'b00, acc);
    bus.in_valid  = 1'b1;
    bus.in_sel    = 1'b1;
    bus.in_data   = 64'hE3;
    bus.out_ready = 2'b00;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    ovf_m = (ovf_m + 65540 > 32'hFFFF) ? 32'hFFFF : ovf_m + 65540;
    check("sat_overflow", 64'(overflow_cnt), 64'hFFFF);
    repeat (3) step(1'b1, 1'b1, 64'hE3, 2'b00, acc);
    check("sat_hold", 64'(overflow_cnt), 64'hFFFF);
    repeat (4) step(1'b0, 1'b0, 64'h0, 2'b11, acc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
